sensors_intf_sysid_ext: RTL and testbench
=========================================

# sensors_intf_sysid_ext

Parametrised system-ID and housekeeping slave for the sensor interface SOC, on the Avalon-MM bus beside the CPU. It returns a build ID and timestamp, and adds a 64-bit uptime counter with coherent snapshot reads and a scratch register. It also provides optional per-channel rising-edge event counters for sensor strobes. Firmware uses it to identify the bitstream, measure elapsed time and sanity-check sensor activity.

## Interface
- ID_VALUE, 32'h0000_0000, system ID word at address 0
- TIMESTAMP, 32'd1444878925, build timestamp word at address 1
- NUM_CH, 4, event channels, 1..8
- CNT_W, 16, event counter width, 1..32
- ADDR_W, 4, word address width; must cover 8+NUM_CH words
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  ADDR_W  word address
- read  in  1  read strobe, one-cycle
- write  in  1  write strobe, one-cycle
- writedata  in  32  write data
- readdata  out  32  read data, registered
- readdatavalid  out  1  high for one cycle with each read response
- event_in  in  NUM_CH  sensor strobes, synchronous to clock

## Operation
- Register map:
  - 0 ID_VALUE (RO)
  - 1 TIMESTAMP (RO)
  - 2 UPTIME_LO (RO; a read latches uptime[63:32] into the HI shadow)
  - 3 UPTIME_HI shadow (RO)
  - 4 SCRATCH (RW, 32 bits)
  - 5 CONTROL
  - 6 CAPABILITY = {8'h0, 8'(CNT_W), 8'(NUM_CH), 8'h01 version}
  - 7 reserved, reads 0
  - 8+i EVENT_CNT[i] (RO, clear-on-read, zero-extended)
- Addresses beyond 8+NUM_CH-1 read 0. Writes to read-only or unmapped addresses are ignored.
- CONTROL:
  - bit0 CLEAR: write-1 pulse that zeroes uptime; reads as 0.
  - bit1 FREEZE: RW level that holds uptime while set.
- Uptime increments by 1 every clock unless FREEZE is set. It wraps from 2^64-1 to 0.
- Event counting:
  - event_prev[i] registers event_in[i].
  - A count occurs when event_in[i]=1 and event_prev[i]=0.
  - The counter saturates at 2^CNT_W-1.
- Simultaneous events:
  - Read and write together is illegal; the write wins and no readdatavalid is issued.
  - Write CLEAR on the same cycle as an increment: uptime becomes 0.
  - Clear-on-read on the same cycle as an edge: the counter becomes 1, the read returns the old value, and the edge is not lost.
  - A UPTIME_LO read returns the value before any same-cycle CLEAR.
- Reset values:
  - readdata=0, readdatavalid=0
  - uptime=0, HI shadow=0
  - SCRATCH=0, FREEZE=0
  - counters=0, event_prev=0
- Reset asserted mid-operation: all state returns to reset values asynchronously, and any pending read response is dropped.

## Timing
- Read latency is exactly 1 cycle: read at edge N gives readdatavalid and readdata at edge N+1.
- Back-to-back reads are accepted every cycle.
- readdata holds its last value when readdatavalid=0.
- A write takes effect at the next edge. A read in the following cycle returns the new value.
- The UPTIME_LO value is sampled at the read edge. The HI shadow updates on the same edge, so a read of address 3 in the next cycle is coherent with it.
- Clear-on-read of an event counter happens at the read edge.

## Configuration
- SYSID_EVENT_CNT_EN defined:
  - Edge detectors and NUM_CH counters are built.
  - CAPABILITY[15:8] = NUM_CH.
- Undefined:
  - No counter logic is built and event_in is ignored.
  - Addresses 8+ read 0.
  - CAPABILITY[15:8] = 0.

## Test plan
- Reset, then read addresses 0, 1, 6 -> ID_VALUE, 1444878925, 0x00_10_04_01 (defaults, macro on); each readdatavalid arrives exactly one cycle after its read.
- Force uptime to 0x0000_0001_FFFF_FFFF, read address 2, then address 3 next cycle -> LO=0xFFFF_FFFF (sampled value), HI=0x0000_0001, not 2.
- Write SCRATCH 0xA5A5_5A5A, read it back -> 0xA5A5_5A5A. Write CONTROL 0x2 -> uptime is constant across 10 cycles. Write 0x1 -> uptime reads small (<4).
- Apply 3 rising edges on event_in[2], read address 10 -> 3; read again -> 0. Put an edge on the read cycle -> that read returns the old value and the next read returns 1.
- Hold event_in[0] high for 100 cycles -> count 1. With CNT_W=4, apply 20 edges -> count 15 (saturated).
- Assert reset_n low mid-read -> readdatavalid=0 and all registers read reset values after release. Recompile without SYSID_EVENT_CNT_EN -> address 8 reads 0 and CAPABILITY[15:8]=0.

Source files
------------

// File: rtl/sensors_intf_sysid_ext_if.sv
// Avalon-MM style slave bus for the system-ID / housekeeping block.
interface sensors_intf_sysid_ext_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/sensors_intf_sysid_ext.sv
// System ID, build timestamp, 64-bit uptime with coherent HI snapshot, scratch,
// and optional per-channel rising-edge event counters (macro SYSID_EVENT_CNT_EN).
module sensors_intf_sysid_ext #(
    parameter logic [31:0] ID_VALUE  = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP = 32'd1444878925,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    sensors_intf_sysid_ext_if.slave bus,
    input  logic [NUM_CH-1:0]    event_in
);
    localparam int unsigned UPT_W = 64;

    logic [UPT_W-1:0] r_uptime;
    logic [31:0]      r_uptime_hi;
    logic [31:0]      r_scratch;
    logic             r_freeze;
    logic [31:0]      r_readdata;
    logic             r_readdatavalid;

    logic        w_rd;
    logic        w_wr;
    logic        w_clear;
    logic [31:0] w_rdata;
    logic [31:0] w_evt_rdata;
    logic [7:0]  w_cap_ch;

    // A write always wins over a simultaneous read, which is then dropped.
    assign w_rd    = bus.read & ~bus.write;
    assign w_wr    = bus.write;
    assign w_clear = w_wr && (bus.address == ADDR_W'(5)) && bus.writedata[0];

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            ADDR_W'(0): w_rdata = ID_VALUE;
            ADDR_W'(1): w_rdata = TIMESTAMP;
            ADDR_W'(2): w_rdata = r_uptime[31:0];
            ADDR_W'(3): w_rdata = r_uptime_hi;
            ADDR_W'(4): w_rdata = r_scratch;
            ADDR_W'(5): w_rdata = {30'd0, r_freeze, 1'b0};
            ADDR_W'(6): w_rdata = {8'h00, 8'(CNT_W), w_cap_ch, 8'h01};
            default:    w_rdata = w_evt_rdata;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_uptime        <= '0;
            r_uptime_hi     <= '0;
            r_scratch       <= '0;
            r_freeze        <= 1'b0;
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= w_rd;
            if (w_rd) begin
                r_readdata <= w_rdata;
            end
            // LO read snapshots HI so a following address-3 read is coherent.
            if (w_rd && bus.address == ADDR_W'(2)) begin
                r_uptime_hi <= r_uptime[63:32];
            end
            if (w_clear) begin
                r_uptime <= '0;
            end else if (!r_freeze) begin
                r_uptime <= r_uptime + UPT_W'(1);
            end
            if (w_wr && bus.address == ADDR_W'(4)) begin
                r_scratch <= bus.writedata;
            end
            if (w_wr && bus.address == ADDR_W'(5)) begin
                r_freeze <= bus.writedata[1];
            end
        end
    end

    assign bus.readdata      = r_readdata;
    assign bus.readdatavalid = r_readdatavalid;

`ifdef SYSID_EVENT_CNT_EN
    logic [NUM_CH-1:0] r_event_prev;
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic [NUM_CH-1:0] w_edge;
    logic [NUM_CH-1:0] w_rd_clr;

    assign w_cap_ch = 8'(NUM_CH);
    assign w_edge   = event_in & ~r_event_prev;

    always_comb begin
        w_evt_rdata = '0;
        w_rd_clr    = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (bus.address == ADDR_W'(8 + i)) begin
                w_evt_rdata = 32'(r_cnt[i]);
                w_rd_clr[i] = w_rd;
            end
        end
    end

    // Clear-on-read reloads with the same-cycle edge so no event is lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_event_prev <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_event_prev <= event_in;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (w_rd_clr[i]) begin
                    r_cnt[i] <= CNT_W'(w_edge[i]);
                end else if (w_edge[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    logic w_unused_events;

    assign w_cap_ch        = 8'h00;
    assign w_evt_rdata     = '0;
    assign w_unused_events = ^event_in;
`endif

endmodule

// File: tb/tb_sensors_intf_sysid_ext.sv
// Directed self-checking bench for sensors_intf_sysid_ext; a second instance
// with CNT_W=4 exercises counter saturation.
module tb_sensors_intf_sysid_ext;
    localparam logic [31:0] TS = 32'd1444878925;
`ifdef SYSID_EVENT_CNT_EN
    localparam logic [31:0] EXP_CAP = 32'h0010_0401;
`else
    localparam logic [31:0] EXP_CAP = 32'h0010_0001;
`endif

    logic       clock;
    logic       reset_n;
    logic [3:0] event_in;
    logic [3:0] event_in2;
    int         errors;
    int         checks;

    sensors_intf_sysid_ext_if #(.ADDR_W(4)) bus  ();
    sensors_intf_sysid_ext_if #(.ADDR_W(4)) bus2 ();

    sensors_intf_sysid_ext dut (
        .clock(clock), .reset_n(reset_n), .bus(bus.slave), .event_in(event_in)
    );

    sensors_intf_sysid_ext #(.CNT_W(4)) dut2 (
        .clock(clock), .reset_n(reset_n), .bus(bus2.slave), .event_in(event_in2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] d, output logic v);
        @(negedge clock);
        bus.address = addr;
        bus.read    = 1'b1;
        @(negedge clock);
        bus.read = 1'b0;
        d = bus.readdata;
        v = bus.readdatavalid;
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clock);
        bus.address   = addr;
        bus.writedata = data;
        bus.write     = 1'b1;
        @(negedge clock);
        bus.write = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        checks++;
        if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdv=%b rd=%h, expected 0/0", bus.readdatavalid, bus.readdata);
        end
        bus_read(4'd0, d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b1) begin
            errors++; $display("FAIL id: got %h v=%b, expected 00000000 v=1", d, v);
        end
        bus_read(4'd1, d, v);
        checks++;
        if (d !== TS || v !== 1'b1) begin
            errors++; $display("FAIL timestamp: got %h v=%b, expected %h v=1", d, v, TS);
        end
        @(negedge clock);
        checks++;
        if (bus.readdatavalid !== 1'b0 || bus.readdata !== TS) begin
            errors++;
            $display("FAIL rd_hold: rdv=%b rd=%h, expected 0 and %h", bus.readdatavalid, bus.readdata, TS);
        end
        bus_read(4'd6, d, v);
        checks++;
        if (d !== EXP_CAP || v !== 1'b1) begin
            errors++; $display("FAIL capability: got %h v=%b, expected %h", d, v, EXP_CAP);
        end
        for (int a = 3; a <= 5; a++) begin
            bus_read(4'(a), d, v);
            checks++;
            if (d !== 32'h0) begin
                errors++; $display("FAIL reset_reg%0d: got %h, expected 0", a, d);
            end
        end
        bus_read(4'd15, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL unmapped: got %h, expected 0", d);
        end
    endtask

    task automatic test_snapshot();
        logic [31:0] d;
        logic        v;
        @(negedge clock);
        force dut.r_uptime = 64'h0000_0001_FFFF_FFFF;
        bus.address = 4'd2;
        bus.read    = 1'b1;
        @(negedge clock);
        bus.read = 1'b0;
        release dut.r_uptime;
        checks++;
        if (bus.readdata !== 32'hFFFF_FFFF || bus.readdatavalid !== 1'b1) begin
            errors++; $display("FAIL uptime_lo: got %h, expected ffffffff", bus.readdata);
        end
        bus_read(4'd3, d, v);
        checks++;
        if (d !== 32'h0000_0001) begin
            errors++; $display("FAIL uptime_hi: got %h, expected 00000001", d);
        end
    endtask

    task automatic test_scratch();
        logic [31:0] d;
        logic        v;
        bus_write(4'd4, 32'hA5A5_5A5A);
        bus_read(4'd4, d, v);
        checks++;
        if (d !== 32'hA5A5_5A5A) begin
            errors++; $display("FAIL scratch: got %h, expected a5a55a5a", d);
        end
        bus_write(4'd0, 32'hDEAD_BEEF);
        bus_read(4'd0, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL ro_write: got %h, expected 0", d);
        end
    endtask

    task automatic test_freeze_clear();
        logic [31:0] d;
        logic [31:0] a;
        logic        v;
        bus_write(4'd5, 32'h2);
        bus_read(4'd5, d, v);
        checks++;
        if (d !== 32'h2) begin
            errors++; $display("FAIL control_rd: got %h, expected 2", d);
        end
        bus_read(4'd2, a, v);
        repeat (10) @(negedge clock);
        bus_read(4'd2, d, v);
        checks++;
        if (d !== a) begin
            errors++; $display("FAIL freeze: got %h, expected %h", d, a);
        end
        bus_write(4'd5, 32'h1);
        bus_read(4'd2, d, v);
        checks++;
        if (d >= 32'd4) begin
            errors++; $display("FAIL clear: got %h, expected < 4", d);
        end
        bus_read(4'd5, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL control_after: got %h, expected 0", d);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        bus.address = 4'd1;
        bus.read    = 1'b1;
        @(negedge clock);
        bus.address = 4'd6;
        checks++;
        if (bus.readdata !== TS || bus.readdatavalid !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got %h v=%b, expected %h", bus.readdata, bus.readdatavalid, TS);
        end
        @(negedge clock);
        bus.read = 1'b0;
        checks++;
        if (bus.readdata !== EXP_CAP || bus.readdatavalid !== 1'b1) begin
            errors++; $display("FAIL b2b_second: got %h v=%b, expected %h", bus.readdata, bus.readdatavalid, EXP_CAP);
        end
    endtask

    task automatic test_rw_collision();
        logic [31:0] d;
        logic        v;
        @(negedge clock);
        bus.address   = 4'd4;
        bus.writedata = 32'h1234_5678;
        bus.read      = 1'b1;
        bus.write     = 1'b1;
        @(negedge clock);
        bus.read  = 1'b0;
        bus.write = 1'b0;
        checks++;
        if (bus.readdatavalid !== 1'b0) begin
            errors++; $display("FAIL collision_rdv: got %b, expected 0", bus.readdatavalid);
        end
        bus_read(4'd4, d, v);
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++; $display("FAIL collision_wr: got %h, expected 12345678", d);
        end
    endtask

    task automatic test_events();
        logic [31:0] d;
        logic        v;
`ifdef SYSID_EVENT_CNT_EN
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); event_in[2] = 1'b1;
            @(negedge clock); event_in[2] = 1'b0;
        end
        bus_read(4'd10, d, v);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL evt_count: got %0d, expected 3", d); end
        bus_read(4'd10, d, v);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL evt_cor: got %0d, expected 0", d); end
        @(negedge clock);
        bus.address = 4'd10;
        bus.read    = 1'b1;
        event_in[2] = 1'b1;
        @(negedge clock);
        bus.read    = 1'b0;
        event_in[2] = 1'b0;
        checks++;
        if (bus.readdata !== 32'd0) begin
            errors++; $display("FAIL evt_race_old: got %0d, expected 0", bus.readdata);
        end
        bus_read(4'd10, d, v);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL evt_race_new: got %0d, expected 1", d); end
        @(negedge clock); event_in[0] = 1'b1;
        repeat (100) @(negedge clock);
        event_in[0] = 1'b0;
        bus_read(4'd8, d, v);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL evt_level: got %0d, expected 1", d); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clock); event_in2[1] = 1'b1;
            @(negedge clock); event_in2[1] = 1'b0;
        end
        @(negedge clock);
        bus2.address = 4'd9;
        bus2.read    = 1'b1;
        @(negedge clock);
        bus2.read = 1'b0;
        checks++;
        if (bus2.readdata !== 32'd15) begin
            errors++; $display("FAIL evt_saturate: got %0d, expected 15", bus2.readdata);
        end
`else
        @(negedge clock); event_in = 4'hF;
        @(negedge clock); event_in = 4'h0;
        bus_read(4'd8, d, v);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL evt_disabled: got %0d, expected 0", d); end
        bus_read(4'd6, d, v);
        checks++;
        if (d[15:8] !== 8'h00) begin errors++; $display("FAIL cap_ch: got %h, expected 00", d[15:8]); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        v;
        bus_write(4'd4, 32'hCAFE_F00D);
        bus_write(4'd5, 32'h2);
        @(negedge clock);
        bus.address = 4'd4;
        bus.read    = 1'b1;
        @(posedge clock);
        #1;
        reset_n  = 1'b0;
        bus.read = 1'b0;
        #1;
        checks++;
        if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: rdv=%b rd=%h, expected 0/0", bus.readdatavalid, bus.readdata);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        bus_read(4'd4, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_scratch: got %h, expected 0", d); end
        bus_read(4'd5, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_freeze: got %h, expected 0", d); end
        bus_read(4'd3, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h, expected 0", d); end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset_n       = 1'b0;
        event_in      = '0;
        event_in2     = '0;
        bus.address   = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = '0;
        bus2.address  = '0;
        bus2.read     = 1'b0;
        bus2.write    = 1'b0;
        bus2.writedata = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        test_reset();
        test_snapshot();
        test_scratch();
        test_freeze_clear();
        test_back_to_back();
        test_rw_collision();
        test_events();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
